// File: rtl/spi_mem_sequencer.sv
// SPI memory slave transaction sequencer: counts conditioned SCLK edges under CS,
// decodes the R/W bit and pulses address latch, memory write and shift-register load.
module spi_mem_sequencer #(
  parameter int WIDTH       = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_n,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic [WIDTH-1:0] sr_pout,
  output logic             addr_we,
  output logic             dm_we,
  output logic             sr_we,
  output logic             miso_oe,
  output logic             busy,
  output logic             protocol_err,
  output logic [3:0]       state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int WW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_GET_ADDR     = 4'd1,
    S_LATCH_ADDR   = 4'd2,
    S_READ_WAIT    = 4'd3,
    S_READ_LOAD    = 4'd4,
    S_READ_SHIFT   = 4'd5,
    S_WRITE_SHIFT  = 4'd6,
    S_WRITE_COMMIT = 4'd7,
    S_DONE         = 4'd8
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_protocol_err;

  state_t        w_next_state;
  logic [CW-1:0] w_bit_cnt_nxt;
  logic [WW-1:0] w_wait_cnt_nxt;
  logic [CW-1:0] w_bit_inc;
  logic          w_last_bit;
  logic          w_err_state;
  logic          w_unused_sr;

  assign w_bit_inc  = r_bit_cnt + 1'b1;
  assign w_last_bit = (w_bit_inc == CW'(WIDTH));

  // Only the R/W flag of the address byte steers the sequencer.
  assign w_unused_sr = ^sr_pout[WIDTH-1:1];

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next_state   = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    if (cs_n && (r_state != S_IDLE)) begin
      w_next_state   = S_IDLE;
      w_bit_cnt_nxt  = '0;
      w_wait_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (!cs_n) begin
          w_next_state  = S_GET_ADDR;
          w_bit_cnt_nxt = '0;
        end
        S_GET_ADDR: if (sclk_rise) begin
          w_bit_cnt_nxt = w_bit_inc;
          if (w_last_bit) w_next_state = S_LATCH_ADDR;
        end
        S_LATCH_ADDR: begin
          if (sr_pout[0]) begin
            w_next_state   = S_READ_WAIT;
            w_wait_cnt_nxt = '0;
          end else begin
            w_next_state  = S_WRITE_SHIFT;
            w_bit_cnt_nxt = '0;
          end
        end
        S_READ_WAIT: begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          if (r_wait_cnt == WW'(MEM_LATENCY - 1)) w_next_state = S_READ_LOAD;
        end
        S_READ_LOAD: begin
          w_next_state  = S_READ_SHIFT;
          w_bit_cnt_nxt = '0;
        end
        S_READ_SHIFT: if (sclk_rise) begin
          w_bit_cnt_nxt = w_bit_inc;
          if (w_last_bit) w_next_state = S_DONE;
        end
        S_WRITE_SHIFT: if (sclk_rise) begin
          w_bit_cnt_nxt = w_bit_inc;
          if (w_last_bit) w_next_state = S_WRITE_COMMIT;
        end
        S_WRITE_COMMIT: w_next_state = S_DONE;
        S_DONE:         w_next_state = S_DONE;
        default:        w_next_state = S_IDLE;
      endcase
    end
  end

  // SCLK activity is illegal whenever the FSM is not expecting a bit.
  assign w_err_state = (r_state == S_LATCH_ADDR) || (r_state == S_READ_WAIT) ||
                       (r_state == S_READ_LOAD)  || (r_state == S_WRITE_COMMIT) ||
                       (r_state == S_DONE);

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if ((r_state == S_IDLE) && !cs_n)
        r_protocol_err <= 1'b0;
      else if (w_err_state && (sclk_rise || sclk_fall))
        r_protocol_err <= 1'b1;
    end
  end

  // Moore outputs decoded straight from the state register, so reset clears them at once.
  assign addr_we      = (r_state == S_LATCH_ADDR);
  assign sr_we        = (r_state == S_READ_LOAD);
  assign dm_we        = (r_state == S_WRITE_COMMIT);
  assign miso_oe      = (r_state == S_READ_SHIFT);
  assign busy         = (r_state != S_IDLE);
  assign protocol_err = r_protocol_err;
  assign state        = r_state;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Directed self-checking bench for spi_mem_sequencer (WIDTH=8, MEM_LATENCY=1).
module tb_spi_mem_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       sclk_rise;
  logic       sclk_fall;
  logic [7:0] sr_pout;
  logic       addr_we, dm_we, sr_we, miso_oe, busy, protocol_err;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  spi_mem_sequencer #(.WIDTH(8), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall), .sr_pout(sr_pout), .addr_we(addr_we),
    .dm_we(dm_we), .sr_we(sr_we), .miso_oe(miso_oe), .busy(busy),
    .protocol_err(protocol_err), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge: pulse counts and cycle stamps.
  logic mon_clr;
  int n_addr, n_dm, n_sr, n_miso, c_addr, c_dm, c_sr;
  int miso_first, miso_last, rise_n, excl;
  int rise_cyc [32];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_addr <= 0; n_dm <= 0; n_sr <= 0; n_miso <= 0;
      c_addr <= -1; c_dm <= -1; c_sr <= -1;
      miso_first <= -1; miso_last <= -1; rise_n <= 0;
    end else begin
      if (addr_we) begin n_addr <= n_addr + 1; c_addr <= cyc; end
      if (dm_we)   begin n_dm   <= n_dm + 1;   c_dm   <= cyc; end
      if (sr_we)   begin n_sr   <= n_sr + 1;   c_sr   <= cyc; end
      if (miso_oe) begin
        if (n_miso == 0) miso_first <= cyc;
        miso_last <= cyc;
        n_miso    <= n_miso + 1;
      end
      if (sclk_rise && rise_n < 32) begin
        rise_cyc[rise_n] <= cyc;
        rise_n <= rise_n + 1;
      end
    end
    if ((int'(addr_we) + int'(dm_we) + int'(sr_we)) > 1 || (miso_oe && state != 4'd5))
      excl <= excl + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  // One SPI bit: falling edge, then rising edge; the external register shifts on the rise.
  task automatic sclk_bit(input logic b);
    sclk_fall = 1'b1; tick(); sclk_fall = 1'b0;
    repeat (5) tick();
    sclk_rise = 1'b1; tick(); sclk_rise = 1'b0;
    sr_pout = {sr_pout[6:0], b};
    repeat (5) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sclk_bit(v[i]);
  endtask

  task automatic start();
    cs_n = 1'b0;
    tick();
    tick();
  endtask

  task automatic stop();
    cs_n = 1'b1;
    tick();
  endtask

  int sr_before;

  initial begin
    excl = 0;
    reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0;
    sr_pout = 8'h00; mon_clr = 1'b1;
    repeat (3) tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outs", 32'({addr_we, dm_we, sr_we, miso_oe, protocol_err}), 32'd0);
    reset = 1'b0;
    tick();
    mon_clr = 1'b0;
    tick();

    // Write: address 0x54, data 0xA5.
    clr(); start();
    check("wr_getaddr_state", 32'(state), 32'd1);
    send_byte(8'h54);
    send_byte(8'hA5);
    check("wr_addr_cnt", 32'(n_addr), 32'd1);
    check("wr_addr_lat", 32'(c_addr - rise_cyc[7]), 32'd1);
    check("wr_dm_cnt", 32'(n_dm), 32'd1);
    check("wr_dm_lat", 32'(c_dm - rise_cyc[15]), 32'd1);
    check("wr_sr_cnt", 32'(n_sr), 32'd0);
    check("wr_miso_cnt", 32'(n_miso), 32'd0);
    check("wr_done_state", 32'(state), 32'd8);
    check("wr_perr", 32'(protocol_err), 32'd0);
    stop();
    check("wr_idle_state", 32'(state), 32'd0);
    check("wr_idle_busy", 32'(busy), 32'd0);
    tick();

    // Read: address 0x55.
    clr(); start();
    send_byte(8'h55);
    send_byte(8'h3C);
    check("rd_addr_cnt", 32'(n_addr), 32'd1);
    check("rd_addr_lat", 32'(c_addr - rise_cyc[7]), 32'd1);
    check("rd_sr_cnt", 32'(n_sr), 32'd1);
    check("rd_sr_lat", 32'(c_sr - c_addr), 32'd2);
    check("rd_miso_first", 32'(miso_first - c_sr), 32'd1);
    check("rd_miso_last", 32'(miso_last - rise_cyc[15]), 32'd0);
    check("rd_dm_cnt", 32'(n_dm), 32'd0);
    check("rd_done_state", 32'(state), 32'd8);
    check("rd_done_miso", 32'(miso_oe), 32'd0);
    check("rd_perr", 32'(protocol_err), 32'd0);
    stop();
    tick();

    // Abort after 11 rises of a write.
    clr(); start();
    send_byte(8'h54);
    for (int i = 0; i < 3; i++) sclk_bit(1'b1);
    check("ab_shift_state", 32'(state), 32'd6);
    cs_n = 1'b1;
    tick();
    check("ab_state", 32'(state), 32'd0);
    check("ab_perr", 32'(protocol_err), 32'd0);
    repeat (5) tick();
    check("ab_dm_cnt", 32'(n_dm), 32'd0);
    check("ab_addr_cnt", 32'(n_addr), 32'd1);

    // cs_n rises together with the 16th rise.
    clr(); start();
    send_byte(8'h54);
    for (int i = 0; i < 7; i++) sclk_bit(1'b0);
    sclk_fall = 1'b1; tick(); sclk_fall = 1'b0;
    repeat (5) tick();
    sclk_rise = 1'b1; cs_n = 1'b1;
    tick();
    sclk_rise = 1'b0;
    check("race_state", 32'(state), 32'd0);
    repeat (5) tick();
    check("race_dm_cnt", 32'(n_dm), 32'd0);

    // Overclock: three extra rises in DONE.
    clr(); start();
    send_byte(8'h54);
    send_byte(8'h0F);
    check("oc_pre_perr", 32'(protocol_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      sclk_rise = 1'b1; tick(); sclk_rise = 1'b0; tick();
    end
    check("oc_perr", 32'(protocol_err), 32'd1);
    check("oc_state", 32'(state), 32'd8);
    check("oc_addr_cnt", 32'(n_addr), 32'd1);
    check("oc_dm_cnt", 32'(n_dm), 32'd1);
    check("oc_sr_cnt", 32'(n_sr), 32'd0);
    cs_n = 1'b1;
    tick();
    check("oc_idle_state", 32'(state), 32'd0);
    check("oc_idle_perr", 32'(protocol_err), 32'd1);
    tick();
    cs_n = 1'b0;
    check("oc_hold_perr", 32'(protocol_err), 32'd1);
    tick();
    check("oc_start_state", 32'(state), 32'd1);
    check("oc_start_perr", 32'(protocol_err), 32'd0);
    stop();
    tick();

    // Asynchronous reset in the middle of READ_SHIFT.
    clr(); start();
    send_byte(8'h55);
    for (int i = 0; i < 3; i++) sclk_bit(1'b1);
    check("rst_pre_state", 32'(state), 32'd5);
    check("rst_pre_miso", 32'(miso_oe), 32'd1);
    sr_before = n_sr;
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_miso", 32'(miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cs_n = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) sclk_bit(1'b0);
    check("rst_sr_cnt", 32'(n_sr), 32'(sr_before));
    check("rst_dm_cnt", 32'(n_dm), 32'd0);
    check("rst_after_state", 32'(state), 32'd0);

    check("pulse_exclusive", 32'(excl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_sequencer.md
Name: spi_mem_sequencer

Overview:
Transaction controller for the SPI memory slave. It counts conditioned SCLK edges while CS is asserted and decodes the address/command byte. It then sequences the address latch, data memory write enable, shift-register parallel load and MISO output enable. It replaces ad-hoc sequencing with a single clk-domain FSM that aborts cleanly on CS deassertion.

Parameters:
WIDTH, 8, bits per SPI byte (address byte and data byte)
MEM_LATENCY, 1, clk cycles from addr_we pulse to valid data-memory read output (1..4)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high; forces IDLE and all outputs low
cs_n  input  1  conditioned chip select, active low
sclk_rise  input  1  one-clk pulse on conditioned SCLK rising edge
sclk_fall  input  1  one-clk pulse on conditioned SCLK falling edge (used only for protocol_err checks)
sr_pout  input  WIDTH  shift-register parallel output; bit 0 = R/W flag of address byte (1 = read)
addr_we  output  1  one-clk pulse: address latch captures sr_pout
dm_we  output  1  one-clk pulse: data memory writes sr_pout at latched address
sr_we  output  1  one-clk pulse: shift register parallel-loads data memory output
miso_oe  output  1  tristate enable for MISO (1 = drive)
busy  output  1  high in every state except IDLE
protocol_err  output  1  sticky; set on illegal SCLK activity, cleared on next IDLE->GET_ADDR
state  output  4  current state encoding, for debug/LEDs

Behaviour:
- Reset (async, any time, including mid-transaction): state=IDLE, bit_cnt=0, wait_cnt=0, and all outputs 0. No memory write occurs.
- State encoding: IDLE=0, GET_ADDR=1, LATCH_ADDR=2, READ_WAIT=3, READ_LOAD=4, READ_SHIFT=5, WRITE_SHIFT=6, WRITE_COMMIT=7, DONE=8.
- bit_cnt is $clog2(WIDTH+1) bits wide and is cleared on every state entry that counts.
- Global abort: cs_n=1 in any non-IDLE state forces IDLE on the next edge.
  - Abort has priority over sclk_rise arriving in the same cycle.
  - No pulse outputs are issued in the abort cycle.
  - If the FSM is in WRITE_COMMIT or READ_LOAD, its pulse for that cycle still issues, since outputs are Moore outputs of the current state.
- IDLE: when cs_n=0, go to GET_ADDR with bit_cnt=0; clear protocol_err.
- GET_ADDR: each sclk_rise increments bit_cnt. The rise that makes bit_cnt==WIDTH moves the FSM to LATCH_ADDR.
- LATCH_ADDR (1 cycle): addr_we=1.
  - sr_pout[0]=1: go to READ_WAIT with wait_cnt=0.
  - sr_pout[0]=0: go to WRITE_SHIFT with bit_cnt=0.
- READ_WAIT: increments wait_cnt each cycle and stays for exactly MEM_LATENCY cycles, then goes to READ_LOAD.
- READ_LOAD (1 cycle): sr_we=1, then go to READ_SHIFT with bit_cnt=0.
- READ_SHIFT: miso_oe=1 for the whole state. Each sclk_rise increments bit_cnt; at bit_cnt==WIDTH, go to DONE.
- WRITE_SHIFT: each sclk_rise increments bit_cnt; at bit_cnt==WIDTH, go to WRITE_COMMIT. This lets the data byte settle in the shift register one clk later.
- WRITE_COMMIT (1 cycle): dm_we=1, then go to DONE.
- DONE: all pulses and miso_oe low. Extra SCLK edges set protocol_err. Stay until cs_n=1, then go to IDLE.
- protocol_err is set by any sclk_rise or sclk_fall seen in LATCH_ADDR, READ_WAIT, READ_LOAD, WRITE_COMMIT or DONE. The edge is otherwise ignored (not counted).
- Pulse outputs are mutually exclusive and each is high for exactly one clk per transaction at most.
- miso_oe is never high outside READ_SHIFT.
- Latency: addr_we fires 1 clk after the 8th address sclk_rise. sr_we fires MEM_LATENCY+1 clk after addr_we. dm_we fires 1 clk after the 8th data sclk_rise.
- Back-to-back transactions require cs_n to return high for at least 1 clk; IDLE is always visited.

Test Plan:
1. Reset mid-READ_SHIFT (reset=1 for 1 clk) -> state=0, miso_oe=0, busy=0 immediately (async), with no sr_we/dm_we afterwards.
2. Write: cs_n=0, address byte 0x54 (R/W=0), then data byte 0xA5, then cs_n=1 -> exactly one addr_we 1 clk after the 8th rise, then exactly one dm_we 1 clk after the 16th rise; miso_oe stays 0; state returns to 0.
3. Read, MEM_LATENCY=1: address byte 0x55 (R/W=1) -> addr_we, then sr_we exactly 2 clk later. miso_oe=1 from the following clk until 1 clk after the 8th data rise, then state=8.
4. Abort: cs_n rises after 11 sclk_rise pulses of a write -> no dm_we, state=0 next clk, protocol_err=0.
5. Simultaneous cs_n=1 and the 16th sclk_rise in WRITE_SHIFT -> no dm_we, state=0.
6. Overclock: 3 extra sclk_rise pulses in DONE -> protocol_err=1 held until the next cs_n=0 transaction start, then it clears; no extra pulses.
